// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 memory path.
//   WORD_W        : datapath / SRAM word width
//   LC3_SRAM_WAIT : default number of extra SRAM access cycles
//   mem_state_t   : states of the MAR/MDR access controller
package lc3_pkg;

    localparam int WORD_W        = 16;
    localparam int LC3_SRAM_WAIT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ACC,
        ST_RD_DONE,
        ST_WR_ACC,
        ST_WR_DONE
    } mem_state_t;

endpackage

// File: rtl/lc3_reg16.sv
// 16-bit register with synchronous active-high reset and load enable.
//   Clk   : clock, rising edge
//   Reset : synchronous reset, clears q
//   ld    : load d into q
//   d     : data in
//   q     : registered data out
module lc3_reg16
    import lc3_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ld,
    input  logic [WORD_W-1:0] d,
    output logic [WORD_W-1:0] q
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 MAR/MDR memory-access controller.
// Latches the address in MAR and write data in MDR from the datapath bus,
// runs the SRAM read/write strobes for WAIT_CYCLES+1 cycles, captures read
// data into MDR and pulses R for one cycle when the access completes.
//   Clk, Reset      : clock and synchronous active-high reset
//   LD_MAR, LD_MDR  : load MAR / MDR from from_bus (honoured only when idle)
//   MEM_REQ, MEM_WE : start an access (read when MEM_WE=0), sampled when idle
//   from_bus        : datapath bus value
//   Data_from_SRAM  : SRAM read data
//   MAR, MDR        : address / data registers
//   Data_to_SRAM    : write data (always MDR); SRAM_DRIVE enables the tristate
//   CE_N/OE_N/WE_N  : active-low SRAM strobes
//   R               : one-cycle completion pulse
//   BUSY            : high outside IDLE
module lc3_mem_ctrl
    import lc3_pkg::*;
#(
    parameter int WAIT_CYCLES = LC3_SRAM_WAIT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              MEM_REQ,
    input  logic              MEM_WE,
    input  logic [WORD_W-1:0] from_bus,
    input  logic [WORD_W-1:0] Data_from_SRAM,
    output logic [WORD_W-1:0] MAR,
    output logic [WORD_W-1:0] MDR,
    output logic [WORD_W-1:0] Data_to_SRAM,
    output logic              SRAM_DRIVE,
    output logic              CE_N,
    output logic              OE_N,
    output logic              WE_N,
    output logic              R,
    output logic              BUSY
);

    localparam int CNT_W = ($clog2(WAIT_CYCLES + 1) < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mar_ld, mdr_ld;
    logic [WORD_W-1:0] mdr_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes, R and BUSY decode only state_q; inputs reach only the
    // next-state and register-load terms.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mar_ld     = 1'b0;
        mdr_ld     = 1'b0;
        mdr_d      = from_bus;
        CE_N       = 1'b1;
        OE_N       = 1'b1;
        WE_N       = 1'b1;
        SRAM_DRIVE = 1'b0;
        R          = 1'b0;
        BUSY       = 1'b1;

        case (state_q)
            ST_IDLE: begin
                BUSY   = 1'b0;
                mar_ld = LD_MAR;
                mdr_ld = LD_MDR;
                if (MEM_REQ) begin
                    cnt_d   = CNT_LOAD;
                    state_d = MEM_WE ? ST_WR_ACC : ST_RD_ACC;
                end
            end
            ST_RD_ACC: begin
                CE_N = 1'b0;
                OE_N = 1'b0;
                if (cnt_q == '0) begin
                    // MDR mux switches to the SRAM side for the capture edge
                    mdr_ld  = 1'b1;
                    mdr_d   = Data_from_SRAM;
                    state_d = ST_RD_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RD_DONE: begin
                R       = 1'b1;
                state_d = ST_IDLE;
            end
            ST_WR_ACC: begin
                CE_N       = 1'b0;
                WE_N       = 1'b0;
                SRAM_DRIVE = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_WR_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WR_DONE: begin
                // WE_N released while data is still driven for hold time
                SRAM_DRIVE = 1'b1;
                R          = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    lc3_reg16 u_mar (
        .Clk   (Clk),
        .Reset (Reset),
        .ld    (mar_ld),
        .d     (from_bus),
        .q     (MAR)
    );

    lc3_reg16 u_mdr (
        .Clk   (Clk),
        .Reset (Reset),
        .ld    (mdr_ld),
        .d     (mdr_d),
        .q     (MDR)
    );

    assign Data_to_SRAM = MDR;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Testbench for lc3_mem_ctrl: one instance with WAIT_CYCLES=2 (index 0) and
// one with WAIT_CYCLES=0 (index 1), driven by the same directed stimulus.
// A timeline model (access start edge + wait count) predicts every output.
module tb_lc3_mem_ctrl;

    logic        Clk = 1'b0;
    logic        Reset, LD_MAR, LD_MDR, MEM_REQ, MEM_WE;
    logic [15:0] from_bus, sram_data;

    logic [15:0] mar [2];
    logic [15:0] mdr [2];
    logic [15:0] dts [2];
    logic        drv [2];
    logic        ce  [2];
    logic        oe  [2];
    logic        we  [2];
    logic        r   [2];
    logic        busy[2];

    int n_pass = 0;
    int n_chk  = 0;
    int e      = 0;

    always #5 Clk = ~Clk;

    lc3_mem_ctrl #(.WAIT_CYCLES(2)) dut_w2 (
        .Clk(Clk), .Reset(Reset), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .from_bus(from_bus),
        .Data_from_SRAM(sram_data), .MAR(mar[0]), .MDR(mdr[0]),
        .Data_to_SRAM(dts[0]), .SRAM_DRIVE(drv[0]), .CE_N(ce[0]),
        .OE_N(oe[0]), .WE_N(we[0]), .R(r[0]), .BUSY(busy[0])
    );

    lc3_mem_ctrl #(.WAIT_CYCLES(0)) dut_w0 (
        .Clk(Clk), .Reset(Reset), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .from_bus(from_bus),
        .Data_from_SRAM(sram_data), .MAR(mar[1]), .MDR(mdr[1]),
        .Data_to_SRAM(dts[1]), .SRAM_DRIVE(drv[1]), .CE_N(ce[1]),
        .OE_N(oe[1]), .WE_N(we[1]), .R(r[1]), .BUSY(busy[1])
    );

    function automatic int wc(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (wait=%0d) edge %0d: got %h, expected %h",
                      nm, wc(idx), e, act, exp);
    endtask

    // Model: an access sampled at edge s occupies the strobes after edges
    // s..s+W, reports completion after edge s+W+1, idle from s+W+2 on.
    bit          m_busy [2];
    int          m_start[2];
    bit          m_we   [2];
    logic [15:0] m_mar  [2];
    logic [15:0] m_mdr  [2];

    always @(posedge Clk) begin
        e = e + 1;
        for (int i = 0; i < 2; i++) begin
            if (Reset) begin
                m_busy[i] = 1'b0;
                m_mar[i]  = 16'h0000;
                m_mdr[i]  = 16'h0000;
            end else if (!m_busy[i] || e >= m_start[i] + wc(i) + 3) begin
                if (LD_MAR) m_mar[i] = from_bus;
                if (LD_MDR) m_mdr[i] = from_bus;
                m_busy[i] = MEM_REQ;
                if (MEM_REQ) begin
                    m_start[i] = e;
                    m_we[i]    = MEM_WE;
                end
            end else if (!m_we[i] && e == m_start[i] + wc(i) + 1) begin
                m_mdr[i] = sram_data;
            end
        end
    end

    always @(negedge Clk) begin
        if (e >= 1) begin
            for (int i = 0; i < 2; i++) begin
                bit acc, done;
                acc  = m_busy[i] && e >= m_start[i] && e <= m_start[i] + wc(i);
                done = m_busy[i] && e == m_start[i] + wc(i) + 1;
                chk("m_CE_N",  i, 16'(ce[i]),   16'(!acc));
                chk("m_OE_N",  i, 16'(oe[i]),   16'(!(acc && !m_we[i])));
                chk("m_WE_N",  i, 16'(we[i]),   16'(!(acc && m_we[i])));
                chk("m_DRIVE", i, 16'(drv[i]),  16'((acc || done) && m_we[i]));
                chk("m_R",     i, 16'(r[i]),    16'(done));
                chk("m_BUSY",  i, 16'(busy[i]), 16'(acc || done));
                chk("m_MAR",   i, mar[i], m_mar[i]);
                chk("m_MDR",   i, mdr[i], m_mdr[i]);
                chk("m_DTS",   i, dts[i], m_mdr[i]);
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_in();
        LD_MAR = 1'b0; LD_MDR = 1'b0; MEM_REQ = 1'b0; MEM_WE = 1'b0;
    endtask

    initial begin
        int cnt;
        int last [2];
        int pulses [2];

        Reset = 1'b1; idle_in(); from_bus = 16'h0000; sram_data = 16'h0000;
        step(); step();
        Reset = 1'b0;
        step();

        // Reset in the middle of a read access
        LD_MAR = 1'b1; from_bus = 16'h2222; MEM_REQ = 1'b1; sram_data = 16'h7777;
        step();
        idle_in();
        chk("t1_in_access", 0, 16'(ce[0]), 16'h0);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("t1_CE_N", 0, 16'(ce[0]), 16'h1);
        chk("t1_OE_N", 0, 16'(oe[0]), 16'h1);
        chk("t1_WE_N", 0, 16'(we[0]), 16'h1);
        chk("t1_MAR",  0, mar[0], 16'h0000);
        chk("t1_MDR",  0, mdr[0], 16'h0000);
        chk("t1_R",    0, 16'(r[0]), 16'h0);
        chk("t1_BUSY", 0, 16'(busy[0]), 16'h0);
        step();

        // Basic read, 3 strobe cycles then R with captured data
        LD_MAR = 1'b1; from_bus = 16'h3000; MEM_REQ = 1'b1; sram_data = 16'h1234;
        step();
        idle_in(); from_bus = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            chk("t2_OE_N_low", 0, 16'(oe[0]), 16'h0);
            chk("t2_CE_N_low", 0, 16'(ce[0]), 16'h0);
            chk("t2_MAR",      0, mar[0], 16'h3000);
            step();
        end
        chk("t2_R",      0, 16'(r[0]), 16'h1);
        chk("t2_MDR",    0, mdr[0], 16'h1234);
        chk("t2_OE_N_hi",0, 16'(oe[0]), 16'h1);
        step();
        chk("t2_R_clr",  0, 16'(r[0]), 16'h0);
        chk("t2_MDR_hold", 0, mdr[0], 16'h1234);
        step();

        // Basic write
        LD_MAR = 1'b1; from_bus = 16'h0042;
        step();
        LD_MAR = 1'b0; LD_MDR = 1'b1; from_bus = 16'hBEEF; MEM_REQ = 1'b1; MEM_WE = 1'b1;
        step();
        idle_in(); from_bus = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            chk("t3_WE_N_low", 0, 16'(we[0]), 16'h0);
            chk("t3_addr",     0, mar[0], 16'h0042);
            chk("t3_data",     0, dts[0], 16'hBEEF);
            chk("t3_drive",    0, 16'(drv[0]), 16'h1);
            step();
        end
        chk("t3_WE_N_hi", 0, 16'(we[0]), 16'h1);
        chk("t3_drive_hold", 0, 16'(drv[0]), 16'h1);
        chk("t3_R", 0, 16'(r[0]), 16'h1);
        step();
        chk("t3_drive_off", 0, 16'(drv[0]), 16'h0);
        step();

        // Busy lock-out during a read
        LD_MAR = 1'b1; from_bus = 16'h1111; MEM_REQ = 1'b1; sram_data = 16'h5A5A;
        step();
        LD_MAR = 1'b1; LD_MDR = 1'b1; MEM_REQ = 1'b1; MEM_WE = 1'b1; from_bus = 16'hFFFF;
        step();
        idle_in(); from_bus = 16'h0000;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (r[0] === 1'b1) cnt++;
            step();
        end
        chk("t4_one_R", 0, 16'(cnt), 16'd1);
        chk("t4_MAR",   0, mar[0], 16'h1111);
        chk("t4_MDR",   0, mdr[0], 16'h5A5A);
        chk("t4_idle",  0, 16'(busy[0]), 16'h0);

        // Zero-wait read on the WAIT_CYCLES=0 instance
        LD_MAR = 1'b1; from_bus = 16'h0010; MEM_REQ = 1'b1; sram_data = 16'h0001;
        step();
        idle_in(); from_bus = 16'h0000;
        chk("t5_CE_N_low", 1, 16'(ce[1]), 16'h0);
        chk("t5_OE_N_low", 1, 16'(oe[1]), 16'h0);
        step();
        chk("t5_CE_N_hi", 1, 16'(ce[1]), 16'h1);
        chk("t5_R",       1, 16'(r[1]), 16'h1);
        chk("t5_MDR",     1, mdr[1], 16'h0001);
        step();
        chk("t5_R_clr",   1, 16'(r[1]), 16'h0);
        repeat (4) step();

        // Back-to-back: MEM_REQ held high
        MEM_REQ = 1'b1; sram_data = 16'hC0DE;
        last[0] = -1; last[1] = -1; pulses[0] = 0; pulses[1] = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (r[i] === 1'b1) begin
                    if (last[i] >= 0) chk("t6_spacing", i, 16'(e - last[i]), 16'(wc(i) + 3));
                    last[i] = e;
                    pulses[i]++;
                end
            end
        end
        idle_in();
        chk("t6_pulses_w2", 0, 16'(pulses[0] >= 3), 16'h1);
        chk("t6_pulses_w0", 1, 16'(pulses[1] >= 5), 16'h1);
        repeat (6) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
